// File: rtl/step_sched_pkg.sv
// -----------------------------------------------------------------------------
// step_sched_pkg
// Shared definitions for the step pulse scheduler:
//   - DEF_CNT_W  : default width of the period / phase counters
//   - DEF_STEP_W : default width of the step count
//   - sched_state_t : scheduler state encoding (IDLE, SETUP, HIGH, LOW, DONE)
// -----------------------------------------------------------------------------
package step_sched_pkg;

    localparam int DEF_CNT_W  = 28;
    localparam int DEF_STEP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/step_phase_timer.sv
// -----------------------------------------------------------------------------
// step_phase_timer
// Loadable down-counter that times every phase of a move (direction setup,
// step high, step low). Loading value N-1 makes tc rise N cycles later: the
// counter shows N-1 in the first cycle of the phase and 0 (tc=1) in the last.
//
// Ports:
//   clock_in  in  1      system clock, rising edge
//   reset     in  1      asynchronous active-high reset, clears the count
//   load      in  1      load load_val on the next rising edge
//   load_val  in  CNT_W  value to load (phase length minus one)
//   tc        out 1      terminal count: count has reached zero
// -----------------------------------------------------------------------------
module step_phase_timer
    import step_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            // Parks at zero so tc stays asserted until the next load.
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/step_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// step_pulse_scheduler
// Generates a train of step pulses for a stepper driver. A move command gives
// the number of steps, the rise-to-rise period and the direction. dir_out is
// updated at accept, then DIR_SETUP cycles later the first step rises; each
// step is high for PULSE_W cycles and the train repeats with an exact period
// of max(cmd_period, 2*PULSE_W). A one-cycle done pulse closes every move;
// aborted accompanies done when the move was cut short by abort.
// DIR_SETUP and PULSE_W must both be at least 1.
//
// Ports:
//   clock_in    in  1       system clock, rising edge
//   reset       in  1       asynchronous active-high reset
//   cmd_valid   in  1       move command offered
//   cmd_ready   out 1       scheduler idle and abort low: command will be taken
//   cmd_period  in  CNT_W   step period in cycles (rise to rise)
//   cmd_steps   in  STEP_W  number of step pulses (0 = empty move)
//   cmd_dir     in  1       direction for this move
//   abort       in  1       terminate the move in progress
//   step_out    out 1       step pulse to the driver (flop output)
//   dir_out     out 1       direction to the driver (flop output)
//   busy        out 1       move in progress (state not IDLE)
//   done        out 1       one-cycle completion pulse
//   aborted     out 1       one-cycle pulse with done when ended by abort
//   steps_left  out STEP_W  pulses not yet started
// -----------------------------------------------------------------------------
module step_pulse_scheduler
    import step_sched_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int PULSE_W   = 100,
    parameter int DIR_SETUP = 50
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_period,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic              abort,
    output logic              step_out,
    output logic              dir_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_left
);

    localparam logic [CNT_W-1:0] PULSE_CNT  = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_W);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(PULSE_W - 1);

    // The low phase must be at least as long as the high phase, so short
    // requested periods saturate at twice the pulse width.
    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    sched_state_t     state;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] low_load;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_tc;

    assign cmd_ready = (state == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;

    // Low phase = period - PULSE_W cycles; timer takes length minus one.
    assign low_load  = period_eff - PULSE_CNT - CNT_W'(1);

    // Timer reloads on the same edge that enters the next timed phase, so
    // consecutive phases join without a gap and rises stay exactly one
    // period apart.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = HIGH_LOAD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    timer_load = 1'b1;
                    timer_val  = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (!abort && timer_tc) begin
                    timer_load = 1'b1;
                    timer_val  = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (!abort && timer_tc) begin
                    timer_load = 1'b1;
                    timer_val  = low_load;
                end
            end
            ST_LOW: begin
                if (!abort && timer_tc && (steps_left != '0)) begin
                    timer_load = 1'b1;
                    timer_val  = HIGH_LOAD;
                end
            end
            default: begin
                timer_load = 1'b0;
                timer_val  = HIGH_LOAD;
            end
        endcase
    end

    step_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock_in (clock_in),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            period_eff <= '0;
            steps_left <= '0;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        period_eff <= clamp_period(cmd_period);
                        steps_left <= cmd_steps;
                        busy       <= 1'b1;
                        if (cmd_steps == '0) begin
                            // Empty move: report completion, leave direction alone.
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_SETUP;
                            dir_out <= cmd_dir;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (timer_tc) begin
                        state      <= ST_HIGH;
                        step_out   <= 1'b1;
                        steps_left <= steps_left - STEP_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (abort) begin
                        state    <= ST_DONE;
                        step_out <= 1'b0;
                        done     <= 1'b1;
                        aborted  <= 1'b1;
                    end else if (timer_tc) begin
                        state    <= ST_LOW;
                        step_out <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (timer_tc) begin
                        if (steps_left != '0) begin
                            state      <= ST_HIGH;
                            step_out   <= 1'b1;
                            steps_left <= steps_left - STEP_W'(1);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    step_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_scheduler
// Reference model: each accepted move is described by its accept cycle, step
// count and effective period; outputs for any cycle follow from arithmetic on
// those numbers (rise k at first + k*P, done at first + n*P). Directed moves
// pin the model with hand-computed cycle numbers, then randomized traffic with
// aborts and occasional resets runs against the model.
// -----------------------------------------------------------------------------
module tb_step_pulse_scheduler;

    localparam int CNT_W     = 28;
    localparam int STEP_W    = 16;
    localparam int PULSE_W   = 4;
    localparam int DIR_SETUP = 3;
    localparam int MIN_P     = 2 * PULSE_W;

    logic              clock_in   = 1'b0;
    logic              reset      = 1'b1;
    logic              cmd_valid  = 1'b0;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_period = '0;
    logic [STEP_W-1:0] cmd_steps  = '0;
    logic              cmd_dir    = 1'b0;
    logic              abort      = 1'b0;
    logic              step_out;
    logic              dir_out;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [STEP_W-1:0] steps_left;

    always #5 clock_in = ~clock_in;

    step_pulse_scheduler #(
        .CNT_W     (CNT_W),
        .STEP_W    (STEP_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_period (cmd_period),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .abort      (abort),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit m_in_move    = 1'b0;
    bit m_ab         = 1'b0;
    bit m_dir        = 1'b0;
    int m_t0         = 0;
    int m_n          = 0;
    int m_p          = MIN_P;
    int m_end        = 0;
    int m_last_steps = 0;
    int m_cur        = 0;

    function automatic int m_first();
        return m_t0 + 1 + DIR_SETUP;
    endfunction

    function automatic int m_rises(input int c);
        int r;
        if (c < m_first()) return 0;
        r = (c - m_first()) / m_p + 1;
        return (r > m_n) ? m_n : r;
    endfunction

    function automatic int m_steps_left(input int c);
        if (!m_in_move) return m_last_steps;
        return m_n - m_rises((c < m_end) ? c : m_end - 1);
    endfunction

    function automatic int m_step(input int c);
        int d;
        if (!m_in_move || c < m_first() || c >= m_end) return 0;
        d = c - m_first();
        return ((d / m_p < m_n) && (d % m_p < PULSE_W)) ? 1 : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clock_in or posedge reset);
            if (reset) begin
                m_in_move    = 1'b0;
                m_ab         = 1'b0;
                m_dir        = 1'b0;
                m_last_steps = 0;
            end else begin
                if (!m_in_move) begin
                    if (cmd_valid && !abort) begin
                        m_in_move = 1'b1;
                        m_ab      = 1'b0;
                        m_t0      = m_cur;
                        m_n       = int'(cmd_steps);
                        m_p       = (int'(cmd_period) < MIN_P) ? MIN_P : int'(cmd_period);
                        if (m_n != 0) m_dir = cmd_dir;
                        m_end = (m_n == 0) ? m_cur + 1 : m_cur + 1 + DIR_SETUP + m_n * m_p;
                    end
                end else if (m_cur == m_end) begin
                    m_last_steps = m_steps_left(m_cur);
                    m_in_move    = 1'b0;
                end else if (abort) begin
                    m_end = m_cur + 1;
                    m_ab  = 1'b1;
                end
                m_cur++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock_in);
            chk("step_out",   int'(step_out),   m_step(m_cur));
            chk("dir_out",    int'(dir_out),    int'(m_dir));
            chk("busy",       int'(busy),       int'(m_in_move));
            chk("done",       int'(done),       (m_in_move && m_cur == m_end) ? 1 : 0);
            chk("aborted",    int'(aborted),    (m_in_move && m_cur == m_end && m_ab) ? 1 : 0);
            chk("steps_left", int'(steps_left), m_steps_left(m_cur));
            chk("cmd_ready",  int'(cmd_ready),  (!m_in_move && !abort) ? 1 : 0);
        end
    end

    // ---------------- directed helpers ----------------
    bit h_step [0:63];
    bit h_done [0:63];
    bit h_ab   [0:63];
    bit h_busy [0:63];
    bit h_dir  [0:63];
    bit h_rdy  [0:63];
    int h_sl   [0:63];

    // Called at #1 after an edge with the scheduler idle; that edge+1 accepts.
    task automatic issue(input int steps, input int period, input bit dir);
        cmd_valid  = 1'b1;
        cmd_steps  = STEP_W'(steps);
        cmd_period = CNT_W'(period);
        cmd_dir    = dir;
        @(posedge clock_in); #1;
        cmd_valid  = 1'b0;
    endtask

    // Records cycles first..last after the accepting edge; abort high in abort_at.
    task automatic observe(input int first, input int last, input int abort_at);
        for (int c = first; c <= last; c++) begin
            abort = (c == abort_at);
            @(negedge clock_in);
            h_step[c] = step_out;
            h_done[c] = done;
            h_ab[c]   = aborted;
            h_busy[c] = busy;
            h_dir[c]  = dir_out;
            h_rdy[c]  = cmd_ready;
            h_sl[c]   = int'(steps_left);
            @(posedge clock_in); #1;
        end
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clock_in); #1;
            k++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock_in);
        #1;
        reset = 1'b0;

        // Three steps, period 10, accepted on the first edge after reset.
        issue(3, 10, 1'b1);
        observe(1, 36, 0);
        chk("t1_dir_c1",    int'(h_dir[1]),  1);
        chk("t1_step_c3",   int'(h_step[3]), 0);
        chk("t1_step_c4",   int'(h_step[4]), 1);
        chk("t1_step_c7",   int'(h_step[7]), 1);
        chk("t1_step_c8",   int'(h_step[8]), 0);
        chk("t1_step_c14",  int'(h_step[14]), 1);
        chk("t1_step_c17",  int'(h_step[17]), 1);
        chk("t1_step_c18",  int'(h_step[18]), 0);
        chk("t1_step_c24",  int'(h_step[24]), 1);
        chk("t1_step_c27",  int'(h_step[27]), 1);
        chk("t1_step_c28",  int'(h_step[28]), 0);
        chk("t1_done_c33",  int'(h_done[33]), 0);
        chk("t1_done_c34",  int'(h_done[34]), 1);
        chk("t1_ready_c34", int'(h_rdy[34]), 0);
        chk("t1_ready_c35", int'(h_rdy[35]), 1);
        chk("t1_sl_c4",     h_sl[4], 2);

        // Short period saturates to 2*PULSE_W = 8.
        issue(2, 5, 1'b0);
        observe(1, 22, 0);
        chk("t2_dir_c1",   int'(h_dir[1]),   0);
        chk("t2_step_c3",  int'(h_step[3]),  0);
        chk("t2_step_c4",  int'(h_step[4]),  1);
        chk("t2_step_c11", int'(h_step[11]), 0);
        chk("t2_step_c12", int'(h_step[12]), 1);
        chk("t2_step_c16", int'(h_step[16]), 0);
        chk("t2_done_c19", int'(h_done[19]), 0);
        chk("t2_done_c20", int'(h_done[20]), 1);

        // Empty move: immediate done, direction untouched.
        issue(0, 10, 1'b1);
        observe(1, 5, 0);
        chk("t3_done_c1", int'(h_done[1]), 1);
        chk("t3_dir_c1",  int'(h_dir[1]),  0);
        chk("t3_step_c1", int'(h_step[1]), 0);
        chk("t3_step_c4", int'(h_step[4]), 0);
        chk("t3_busy_c2", int'(h_busy[2]), 0);

        // Abort during the second pulse.
        issue(5, 10, 1'b1);
        observe(1, 20, 16);
        chk("t4_sl_c3",      h_sl[3], 5);
        chk("t4_sl_c4",      h_sl[4], 4);
        chk("t4_step_c16",   int'(h_step[16]), 1);
        chk("t4_done_c16",   int'(h_done[16]), 0);
        chk("t4_step_c17",   int'(h_step[17]), 0);
        chk("t4_done_c17",   int'(h_done[17]), 1);
        chk("t4_abort_c17",  int'(h_ab[17]),   1);
        chk("t4_sl_c17",     h_sl[17], 3);
        chk("t4_busy_c18",   int'(h_busy[18]), 0);

        // Reset in the middle of the first pulse.
        issue(3, 10, 1'b1);
        repeat (4) @(posedge clock_in);
        #2;
        chk("t5_step_before_reset", int'(step_out), 1);
        reset = 1'b1;
        #1;
        chk("t5_step_async", int'(step_out), 0);
        chk("t5_busy_async", int'(busy), 0);
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;
        observe(1, 10, 0);
        for (int c = 1; c <= 10; c++) chk("t5_no_done", int'(h_done[c]), 0);
        issue(1, 8, 1'b0);
        observe(1, 3, 0);
        chk("t5_reaccept_busy", int'(h_busy[1]), 1);
        wait_idle(100);

        // cmd_valid held high through a move; inputs changed mid-move.
        cmd_valid  = 1'b1;
        cmd_steps  = STEP_W'(2);
        cmd_period = CNT_W'(8);
        cmd_dir    = 1'b1;
        @(posedge clock_in); #1;
        observe(1, 5, 0);
        cmd_dir    = 1'b0;
        cmd_period = CNT_W'(20);
        cmd_steps  = STEP_W'(1);
        observe(6, 23, 0);
        cmd_valid  = 1'b0;
        chk("t6_step_c12",  int'(h_step[12]), 1);
        chk("t6_dir_c20",   int'(h_dir[20]),  1);
        chk("t6_done_c20",  int'(h_done[20]), 1);
        chk("t6_busy_c20",  int'(h_busy[20]), 1);
        chk("t6_busy_c21",  int'(h_busy[21]), 0);
        chk("t6_ready_c21", int'(h_rdy[21]),  1);
        chk("t6_busy_c22",  int'(h_busy[22]), 1);
        chk("t6_dir_c22",   int'(h_dir[22]),  0);
        chk("t6_sl_c22",    h_sl[22], 1);
        wait_idle(200);

        // Abort together with cmd_valid while idle: not accepted.
        cmd_valid = 1'b1;
        abort     = 1'b1;
        #1;
        chk("t7_ready_abort", int'(cmd_ready), 0);
        @(posedge clock_in); #1;
        chk("t7_no_accept", int'(busy), 0);
        cmd_valid = 1'b0;
        abort     = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_steps  = STEP_W'($urandom_range(0, 4));
            cmd_period = CNT_W'($urandom_range(0, 20));
            cmd_dir    = ($urandom_range(0, 1) == 1);
            abort      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2;
                reset = 1'b1;
                @(posedge clock_in); #1;
                reset = 1'b0;
            end else begin
                @(posedge clock_in); #1;
            end
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        wait_idle(300);
        repeat (2) @(posedge clock_in);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/step_pulse_scheduler.md
STEP_PULSE_SCHEDULER -- requirements
Module: step_pulse_scheduler

Interface
REQ-001 Parameter CNT_W, default 28: width of period and phase counters.
REQ-002 Parameter STEP_W, default 16: width of step count.
REQ-003 Parameter PULSE_W, default 100: step high time, clock cycles.
REQ-004 Parameter DIR_SETUP, default 50: cycles from dir_out update to first step rise.
REQ-005 clock_in  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  move command offered.
REQ-008 cmd_ready  out  1  scheduler can accept command.
REQ-009 cmd_period  in  CNT_W  step period, cycles (rise to rise).
REQ-010 cmd_steps  in  STEP_W  number of step pulses.
REQ-011 cmd_dir  in  1  direction for this move.
REQ-012 abort  in  1  terminate move in progress.
REQ-013 step_out  out  1  step pulse to driver.
REQ-014 dir_out  out  1  registered direction to driver.
REQ-015 busy  out  1  move in progress (state not IDLE).
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 aborted  out  1  one-cycle pulse, coincident with done, when move ended by abort.
REQ-018 steps_left  out  STEP_W  pulses not yet started.

Function
REQ-019 States SHALL be IDLE, SETUP, HIGH, LOW, DONE.
REQ-020 cmd_ready SHALL equal (state==IDLE && !abort); command accepted on a clock edge where cmd_valid && cmd_ready.
REQ-021 On accept: latch period, load steps_left=cmd_steps, dir_out=cmd_dir, next state SETUP; if cmd_steps==0, next state DONE, dir_out unchanged.
REQ-022 Effective period SHALL be max(cmd_period, 2*PULSE_W), computed at accept in CNT_W bits.
REQ-023 SETUP SHALL last exactly DIR_SETUP cycles, then HIGH.
REQ-024 HIGH: step_out=1 for exactly PULSE_W cycles; steps_left decrements by 1 on HIGH entry; then LOW.
REQ-025 LOW: step_out=0 for exactly (period - PULSE_W) cycles; at end, HIGH if steps_left!=0, else DONE.
REQ-026 Rising edges of step_out SHALL be exactly one effective period apart; no jitter.
REQ-027 DONE SHALL last one cycle with done=1, then IDLE.
REQ-028 Latency: accept at edge 0 -> first step rise at cycle 1+DIR_SETUP.
REQ-029 abort in SETUP/HIGH/LOW: next cycle step_out=0, state DONE, done=1, aborted=1; steps_left holds value.
REQ-030 abort in IDLE or DONE SHALL be ignored; abort with cmd_valid in IDLE: command not accepted.
REQ-031 cmd_valid ignored while busy; inputs not sampled outside accept.
REQ-032 step_out, dir_out SHALL be driven directly from flops (glitch-free).

Reset
REQ-033 reset SHALL asynchronously force state IDLE, step_out=0, dir_out=0, busy=0, done=0, aborted=0, steps_left=0, all counters 0.
REQ-034 reset asserted mid-pulse SHALL drop step_out immediately; no done pulse after release.
REQ-035 First accept possible on first rising edge after reset deasserts.

Structure
REQ-036 Package step_sched_pkg SHALL hold state enumeration and default widths CNT_W, STEP_W.
REQ-037 One sub-module, step_phase_timer: loadable CNT_W down-counter with terminal-count output, shared by SETUP, HIGH, LOW.

Verification (PULSE_W=4, DIR_SETUP=3)
REQ-038 Accept steps=3, period=10, dir=1 at edge 0 -> dir_out=1 at cycle 1; step_out high cycles 4-7, 14-17, 24-27; done at cycle 34; cmd_ready at 35.
REQ-039 Accept steps=2, period=5 -> period clamped to 8; rises at cycles 4 and 12; done at cycle 20.
REQ-040 Accept steps=0 -> no step pulse, done at cycle 1, dir_out unchanged.
REQ-041 steps=5, period=10, abort at cycle 16 -> step_out=0 at 17, done=aborted=1 at 17, steps_left=3.
REQ-042 Assert reset at cycle 5 of steps=3 move -> step_out, busy low immediately; no done; new command accepted after release.
REQ-043 cmd_valid held high during move -> second command accepted only in the cycle after done; abort+cmd_valid in IDLE -> not accepted.
